seq_signed_divider: RTL



---
 rtl/seq_signed_divider_pkg.sv | 25 ++
 rtl/seq_signed_divider_if.sv | 33 +++
 rtl/seq_signed_divider_step.sv | 36 +++
 rtl/seq_signed_divider.sv | 128 ++++++++++++
 4 files changed

// File: rtl/seq_signed_divider_pkg.sv
// ============================================================================
// Module   : div_pkg
// Brief    : Shared constants and FSM encoding for the sequential signed divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int C_WIDTH = 32;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_CALC = 2'd1;
    localparam logic [1:0] C_ST_FIX  = 2'd2;

    // Counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int C_CNT_W = cnt_width(C_WIDTH);

endpackage

`default_nettype wire

// File: rtl/seq_signed_divider_if.sv
// ============================================================================
// Module   : seq_signed_divider_if
// Brief    : Start/done handshake and operand/result bundle for the divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_signed_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/seq_signed_divider_step.sv
// ============================================================================
// Module   : div_step
// Brief    : One restoring shift-compare-subtract iteration on magnitudes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
) (
    input  wire logic [WIDTH:0]   rem,
    input  wire logic [WIDTH-1:0] q,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH:0]   rem_next,
    output logic      [WIDTH-1:0] q_next
);

    // One spare bit on top keeps the whole incoming remainder in the compare.
    logic [WIDTH+1:0] w_shift;

    always_comb begin
        w_shift = {rem, q[WIDTH-1]};
        if (w_shift >= {2'b00, divisor}) begin
            rem_next = (WIDTH+1)'(w_shift - {2'b00, divisor});
            q_next   = {q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = (WIDTH+1)'(w_shift);
            q_next   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_signed_divider.sv
// ============================================================================
// Module   : seq_signed_divider
// Brief    : Signed truncating divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          reset,
    seq_signed_divider_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_n;
    logic             r_sign_d;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_dzo;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_step_rem;
    logic [WIDTH-1:0] w_step_q;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Unsigned negation: the most-negative value maps onto 2^(WIDTH-1) exactly.
    assign w_dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (r_rem),
        .q        (r_q),
        .divisor  (r_dvs),
        .rem_next (w_step_rem),
        .q_next   (w_step_q)
    );

    // On divide-by-zero r_q still holds |dividend|, so restoring its sign returns the dividend.
    always_comb begin
        if (r_dz) begin
            w_q_fix = '1;
            w_r_fix = r_sign_n ? -r_q : r_q;
        end else begin
            w_q_fix = (r_sign_n ^ r_sign_d) ? -r_q : r_q;
            w_r_fix = r_sign_n ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= C_ST_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_dvs    <= '0;
            r_sign_n <= 1'b0;
            r_sign_d <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_quot   <= '0;
            r_remo   <= '0;
            r_dzo    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                C_ST_IDLE: begin
                    if (bus.start) begin
                        r_sign_n <= bus.dividend[WIDTH-1];
                        r_sign_d <= bus.divisor[WIDTH-1];
                        r_q      <= w_dvd_mag;
                        r_dvs    <= w_dvs_mag;
                        r_rem    <= '0;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_busy   <= 1'b1;
                        r_dz     <= (bus.divisor == '0);
                        r_state  <= (bus.divisor == '0) ? C_ST_FIX : C_ST_CALC;
                    end
                end
                C_ST_CALC: begin
                    r_rem <= w_step_rem;
                    r_q   <= w_step_q;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= C_ST_FIX;
                    end
                end
                C_ST_FIX: begin
                    r_quot  <= w_q_fix;
                    r_remo  <= w_r_fix;
                    r_dzo   <= r_dz;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= C_ST_IDLE;
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remo;
    assign bus.div_by_zero = r_dzo;

endmodule

`default_nettype wire
